// File: rtl/tq_chromadc_fh_qt.sv
// tq_chromadc_fh_qt: encoder-side chroma DC path. Collects the four DC terms of
// one 8x8 chroma block, applies a forward 2x2 Hadamard, quantizes the four
// results in parallel and streams the levels out in raster order.
// Optional feature: define TQ_CHROMA_DC_NNZ_EN to add nnz_o, the count of
// nonzero levels in the block (CAVLC TotalCoeff for chroma DC).
module tq_chromadc_fh_qt #(
    parameter int DW = 15,
    parameter int LW = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [DW-1:0] in_coef_i,
    input  logic [5:0]           qp_i,
    input  logic                 intra_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [LW-1:0] out_level_o,
    output logic                 out_last_o
`ifdef TQ_CHROMA_DC_NNZ_EN
    ,
    output logic [2:0]           nnz_o
`endif
);

    // Hadamard outputs need two extra bits; the magnitude-times-MF product
    // needs 14 more, and one guard bit absorbs the rounding offset.
    localparam int FW = DW + 2;
    localparam int SW = DW + 2 + 14 + 1;

    localparam logic [SW-1:0] NEG_LIM = SW'(1) << (LW - 1);
    localparam logic [SW-1:0] POS_LIM = NEG_LIM - SW'(1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_HT      = 2'd1;
    localparam logic [1:0] S_QT      = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]           state;
    logic [1:0]           cnt;
    logic [1:0]           ocnt;
    logic [5:0]           qp_q;
    logic                 intra_q;
    logic signed [DW-1:0] coef       [4];
    logic signed [FW-1:0] f          [4];
    logic signed [FW-1:0] f_next     [4];
    logic signed [LW-1:0] level      [4];
    logic signed [LW-1:0] level_next [4];

    logic [3:0]  qp_div;
    logic [2:0]  qp_mod;
    logic [3:0]  ofs_idx;
    logic [4:0]  shift;
    logic [13:0] mf;
    logic [23:0] ofs;

    // Sign-magnitude quantization: the sign is reapplied after the shift so a
    // zero magnitude can never turn into a negative level.
    function automatic logic signed [LW-1:0] quant(
        input logic signed [FW-1:0] fv,
        input logic [13:0]          mfv,
        input logic [4:0]           sv,
        input logic [23:0]          ofsv
    );
        logic [FW-1:0] mag;
        logic [SW-1:0] acc;
        logic [SW-1:0] q;
        mag = fv[FW-1] ? FW'(-fv) : FW'(fv);
        acc = SW'(mag) * SW'(mfv) + SW'(ofsv);
        q   = acc >> sv;
        if (fv[FW-1]) begin
            if (q >= NEG_LIM) quant = {1'b1, {(LW-1){1'b0}}};
            else              quant = -LW'(q);
        end else begin
            if (q > POS_LIM)  quant = {1'b0, {(LW-1){1'b1}}};
            else              quant = LW'(q);
        end
    endfunction

    // Quantizer parameters derived from the latched (already clamped) QP.
    always_comb begin
        // NOTE: every combinational output gets a value on every path (case
        // defaults included) so no latch is inferred.
        qp_div  = 4'(qp_q / 6'd6);
        qp_mod  = 3'(qp_q % 6'd6);
        shift   = 5'd16 + 5'(qp_div);
        // floor(2^S/6) equals floor(2^(S-1)/3), so one table of floor(2^n/3)
        // serves both roundings: intra looks one entry further up.
        ofs_idx = qp_div + 4'(intra_q);
        case (qp_mod)
            3'd0:    mf = 14'd13107;
            3'd1:    mf = 14'd11916;
            3'd2:    mf = 14'd10082;
            3'd3:    mf = 14'd9362;
            3'd4:    mf = 14'd8192;
            default: mf = 14'd7282;
        endcase
        case (ofs_idx)
            4'd0:    ofs = 24'd10922;
            4'd1:    ofs = 24'd21845;
            4'd2:    ofs = 24'd43690;
            4'd3:    ofs = 24'd87381;
            4'd4:    ofs = 24'd174762;
            4'd5:    ofs = 24'd349525;
            4'd6:    ofs = 24'd699050;
            4'd7:    ofs = 24'd1398101;
            4'd8:    ofs = 24'd2796202;
            default: ofs = 24'd5592405;
        endcase
    end

    // Forward 2x2 Hadamard on the collected coefficients, full width.
    always_comb begin
        f_next[0] = FW'(coef[0]) + FW'(coef[1]) + FW'(coef[2]) + FW'(coef[3]);
        f_next[1] = FW'(coef[0]) - FW'(coef[1]) + FW'(coef[2]) - FW'(coef[3]);
        f_next[2] = FW'(coef[0]) + FW'(coef[1]) - FW'(coef[2]) - FW'(coef[3]);
        f_next[3] = FW'(coef[0]) - FW'(coef[1]) - FW'(coef[2]) + FW'(coef[3]);
    end

    // All four levels are quantized in parallel.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level_next[i] = quant(f[i], mf, shift, ofs);
        end
    end

`ifdef TQ_CHROMA_DC_NNZ_EN
    logic [2:0] nnz_q;
    logic [2:0] nnz_next;

    // Count of nonzero levels, formed alongside the quantizer.
    always_comb begin
        nnz_next = 3'd0;
        for (int i = 0; i < 4; i++) begin
            nnz_next = nnz_next + 3'(level_next[i] != '0);
        end
    end

    // Captured in QT and held through the whole output burst.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          nnz_q <= 3'd0;
        else if (state == S_QT) nnz_q <= nnz_next;
    end

    assign nnz_o = nnz_q;
`endif

    // Block sequencer: COLLECT -> HT -> QT -> OUT -> COLLECT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_COLLECT;
            cnt     <= 2'd0;
            ocnt    <= 2'd0;
            qp_q    <= 6'd0;
            intra_q <= 1'b0;
            // NOTE: the small coefficient/level arrays are reset so an aborted
            // block leaves no stale data visible on the outputs.
            for (int i = 0; i < 4; i++) begin
                coef[i]  <= '0;
                f[i]     <= '0;
                level[i] <= '0;
            end
        end else begin
            case (state)
                S_COLLECT: begin
                    if (in_valid_i) begin
                        coef[cnt] <= in_coef_i;
                        if (cnt == 2'd0) begin
                            qp_q    <= (qp_i > 6'd51) ? 6'd51 : qp_i;
                            intra_q <= intra_i;
                        end
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= S_HT;
                    end
                end
                S_HT: begin
                    for (int i = 0; i < 4; i++) f[i] <= f_next[i];
                    state <= S_QT;
                end
                S_QT: begin
                    for (int i = 0; i < 4; i++) level[i] <= level_next[i];
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        ocnt <= ocnt + 2'd1;
                        if (ocnt == 2'd3) begin
                            ocnt  <= 2'd0;
                            cnt   <= 2'd0;
                            state <= S_COLLECT;
                        end
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    assign in_ready_o  = (state == S_COLLECT);
    assign out_valid_o = (state == S_OUT);
    assign out_last_o  = out_valid_o && (ocnt == 2'd3);
    assign out_level_o = out_valid_o ? level[ocnt] : '0;

endmodule

// File: doc/tq_chromadc_fh_qt.md
Name: tq_chromaDC_FH_QT

Overview:
- Encoder-side chroma DC path: forward 2x2 Hadamard followed by forward quantization of the four chroma DC coefficients of one 8x8 chroma block (Cb or Cr).
- Sits between the 4x4 forward core transform, which supplies the DC terms, and the entropy coder / reconstruction loop.
- The reconstruction loop feeds its output back through the existing decoder-side inverse Hadamard / dequant block.
- Serial valid/ready stream: four coefficients in, four quantized levels out.

Parameters:
- DW, 15, input coefficient width (signed); DC sums of 4x4 residuals are at most ±4080.
- LW, 15, output level width (signed).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input coefficient valid.
- in_ready_o  out  1  block can accept a coefficient.
- in_coef_i  in  DW  signed DC coefficient; raster order c00, c01, c10, c11.
- qp_i  in  6  chroma QP; sampled with c00.
- intra_i  in  1  1 = intra rounding, 0 = inter rounding; sampled with c00.
- out_valid_o  out  1  output level valid.
- out_ready_i  in  1  downstream accepts level.
- out_level_o  out  LW  signed quantized level; order l00, l01, l10, l11.
- out_last_o  out  1  high with l11.

Behaviour:
- Reset is asynchronous, active-low: state=COLLECT, in_ready_o=1, out_valid_o=0, out_level_o=0, out_last_o=0, counters=0, all coefficient/level registers=0.
- FSM COLLECT:
  - in_ready_o=1; each in_valid_i & in_ready_o stores in_coef_i at index cnt, and cnt increments.
  - When cnt=0, qp_i and intra_i are also latched. qp_i>51 is clamped to 51.
  - Acceptance of the 4th coefficient moves the FSM to HT.
- FSM HT (1 cycle):
  - in_ready_o=0; registers f00=c00+c01+c10+c11, f01=c00-c01+c10-c11, f10=c00+c01-c10-c11, f11=c00-c01-c10+c11.
  - Full-width signed arithmetic, DW+2 bits, no overflow. Moves to QT.
- FSM QT (1 cycle):
  - All four levels are computed in parallel and registered.
  - For each f: level = sign(f) * ((|f|*MF + OFS) >> S), with S = 16 + qp/6.
  - MF indexed by qp%6: 13107, 11916, 10082, 9362, 8192, 7282.
  - OFS = floor(2^S/3) if intra, floor(2^S/6) if inter.
  - Product width: DW+2+14 bits unsigned; the result is saturated to the LW signed range.
  - Sign is applied after the shift, so zero never becomes negative. Moves to OUT.
- FSM OUT:
  - out_valid_o=1; out_level_o = level[ocnt]; out_last_o = (ocnt==3).
  - On out_valid_o & out_ready_i, ocnt increments.
  - On the l11 handshake: out_valid_o=0, ocnt=0, cnt=0, go to COLLECT.
  - Output holds stable while out_ready_i=0.
- Latency: first out_valid_o rises 2 cycles after the cycle c11 is accepted.
- Throughput: one block per ≥10 cycles. There is no input overlap with output; in_ready_o=0 in HT/QT/OUT.
- in_valid_i is ignored outside COLLECT.
- out_ready_i while out_valid_o=0 has no effect.
- rst_n_i asserted mid-block discards all partial data immediately; no output is produced for that block.

Optional Feature:
- Macro TQ_CHROMA_DC_NNZ_EN.
- Defined:
  - Adds output nnz_o [2:0], the count of nonzero levels among l00..l11, computed in QT.
  - Held stable from OUT entry until the l11 handshake, and valid whenever out_valid_o=1.
  - Reset value 0. Consumed by CAVLC TotalCoeff for chroma DC.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n_i=0, then release with no input -> in_ready_o=1, out_valid_o=0, out_level_o=0 for 20 cycles.
- Uniform DC: inputs 100,100,100,100, qp=28, intra=1 -> levels 3,0,0,0; out_last_o with the 4th level; nnz_o=1 if enabled.
- Sign handling: inputs -10,10,0,0, qp=0, intra=1 -> f=0,-20,0,-20 -> levels 0,-4,0,-4. Same block with intra=0 -> (20*13107+10922)>>16=4, so levels 0,-4,0,-4.
- Extremes: inputs 4080 x4, qp=0, intra=1 -> l00=3264, others 0. Repeat with qp=60 -> behaves as qp=51.
- Backpressure: out_ready_i toggled 0/1 every cycle during OUT -> each level held stable until handshake, order preserved, in_ready_o=0 until after the l11 handshake; in_valid_i pulses during OUT are ignored.
- Reset mid-operation: assert rst_n_i after 2 accepted inputs and again during OUT -> outputs immediately return to reset values; the next full block of 100 x4 at qp=28 yields 3,0,0,0.
